// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V lb/lh/lw/lbu/lhu/sb/sh/sw requests into
// whole-word transactions on a word-addressed memory. Sub-word stores are
// done as read-modify-write. Bad requests skip the memory and finish with err.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

   state_t      state;
   logic        we;
   logic [2:0]  funct3;
   logic [1:0]  off;
   logic [31:0] wdata;
   logic        err;

   logic        bad;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_val;
   logic [31:0] merged;

   // request legality: funct3 must be supported for the direction, and the
   // address must be naturally aligned for the access size
   always_comb begin
      bad = 1'b0;
      case (funct3_i)
         3'd0:       bad = 1'b0;
         3'd1:       bad = addr_i[0];
         3'd2:       bad = |addr_i[1:0];
         3'd4:       bad = we_i;
         3'd5:       bad = we_i | addr_i[0];
         default:    bad = 1'b1;
      endcase
   end

   // lane extraction and extension of the word read back in WAIT
   always_comb begin
      lane_b   = mem_data_i[{off, 3'b000} +: 8];
      lane_h   = off[1] ? mem_data_i[31:16] : mem_data_i[15:0];
      load_val = mem_data_i;
      case (funct3)
         3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
         3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
         3'd4:    load_val = {24'd0, lane_b};
         3'd5:    load_val = {16'd0, lane_h};
         default: load_val = mem_data_i;
      endcase
   end

   // merge the store lane into the word read back for sb/sh
   always_comb begin
      merged = mem_data_i;
      if (funct3 == 3'd0)
         merged[{off, 3'b000} +: 8] = wdata[7:0];
      else if (off[1])
         merged[31:16] = wdata[15:0];
      else
         merged[15:0] = wdata[15:0];
   end

   // main FSM: request latch, memory sequencing and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         we         <= 1'b0;
         funct3     <= 3'd0;
         off        <= 2'd0;
         wdata      <= 32'd0;
         err        <= 1'b0;
         rdata_o    <= 32'd0;
         mem_addr_o <= 32'd0;
         mem_data_o <= 32'd0;
      end else begin
         case (state)
            IDLE: if (req_i) begin
               we         <= we_i;
               funct3     <= funct3_i;
               off        <= addr_i[1:0];
               wdata      <= wdata_i;
               mem_addr_o <= {addr_i[31:2], 2'b00};
               err        <= bad;
               if (bad)
                  state <= RESP;
               else if (we_i && funct3_i == 3'd2) begin
                  // full-word store needs no read-back
                  mem_data_o <= wdata_i;
                  state      <= WR;
               end else
                  state <= RD;
            end
            RD:   if (mem_ack_i) state <= WAIT;
            WAIT: begin
               // read data is valid only in this cycle
               if (we) begin
                  mem_data_o <= merged;
                  state      <= WR;
               end else begin
                  rdata_o <= load_val;
                  state   <= RESP;
               end
            end
            WR:   if (mem_ack_i) state <= RESP;
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_o      = (state != IDLE);
   assign done_o      = (state == RESP);
   assign err_o       = (state == RESP) & err;
   assign mem_rd_en_o = (state == RD);
   assign mem_wr_en_o = (state == WR);

endmodule
